response_arbiter: RTL and testbench

RESPONSE_ARBITER -- requirements
Module: response_arbiter

---
 rtl/response_arbiter.sv | 122 ++++++++++++
 tb/tb_response_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/response_arbiter.sv
// response_arbiter: round-robin merge of ASC/STL response bytes into one UART byte stream.
// Define RESPONSE_ARBITER_TAG_EN to prefix every burst with a source tag byte ('a' / 's').
module response_arbiter #(
   parameter int MAX_BURST   = 64,
   parameter int IDLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       asc_valid,
   output logic       asc_ready,
   input  logic [7:0] asc_data,
   input  logic       stl_valid,
   output logic       stl_ready,
   input  logic [7:0] stl_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [1:0] grant
);

`ifdef RESPONSE_ARBITER_TAG_EN
   typedef enum logic [1:0] {IDLE, TAG, PASS} state_t;
`else
   typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif

   localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
   localparam logic [7:0] IDLE_C = 8'(IDLE_CYCLES);

   state_t     state, state_nxt;
   logic       gnt_stl, gnt_stl_nxt;    // granted source, 1 = STL
   logic       last_stl, last_stl_nxt;  // source that owned the previous burst
   logic [7:0] byte_cnt, byte_cnt_nxt;
   logic [7:0] idle_cnt, idle_cnt_nxt;
   logic       loadable, load, src_valid, xfer;
   logic [7:0] src_data, load_data;

   assign loadable  = !out_valid || out_ready;
   assign src_valid = gnt_stl ? stl_valid : asc_valid;
   assign src_data  = gnt_stl ? stl_data : asc_data;

   always_comb begin
      state_nxt    = state;
      gnt_stl_nxt  = gnt_stl;
      last_stl_nxt = last_stl;
      byte_cnt_nxt = byte_cnt;
      idle_cnt_nxt = idle_cnt;
      load         = 1'b0;
      load_data    = src_data;
      xfer         = 1'b0;
      asc_ready    = 1'b0;
      stl_ready    = 1'b0;
      grant        = 2'b00;
      case (state)
         IDLE: begin
            if (asc_valid || stl_valid) begin
               // on a tie, the source that did not own the last burst wins
               gnt_stl_nxt  = (asc_valid && stl_valid) ? !last_stl : stl_valid;
               byte_cnt_nxt = '0;
               idle_cnt_nxt = '0;
`ifdef RESPONSE_ARBITER_TAG_EN
               state_nxt    = TAG;
`else
               state_nxt    = PASS;
`endif
            end
         end
`ifdef RESPONSE_ARBITER_TAG_EN
         TAG: begin
            grant = gnt_stl ? 2'b10 : 2'b01;
            if (loadable) begin
               load      = 1'b1;
               load_data = gnt_stl ? 8'h73 : 8'h61;
               state_nxt = PASS;
            end
         end
`endif
         PASS: begin
            grant     = gnt_stl ? 2'b10 : 2'b01;
            asc_ready = !gnt_stl && loadable;
            stl_ready = gnt_stl && loadable;
            xfer      = src_valid && loadable;
            load      = xfer;
            if (xfer) begin
               byte_cnt_nxt = byte_cnt + 8'd1;
               idle_cnt_nxt = '0;
            end else begin
               idle_cnt_nxt = idle_cnt + 8'd1;
            end
            // end test uses next counts so the final byte is still forwarded
            if (byte_cnt_nxt == MAX_B || idle_cnt_nxt == IDLE_C) begin
               state_nxt    = IDLE;
               last_stl_nxt = gnt_stl;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt_stl   <= 1'b0;
         last_stl  <= 1'b1;
         byte_cnt  <= '0;
         idle_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else begin
         state    <= state_nxt;
         gnt_stl  <= gnt_stl_nxt;
         last_stl <= last_stl_nxt;
         byte_cnt <= byte_cnt_nxt;
         idle_cnt <= idle_cnt_nxt;
         if (loadable) begin
            out_valid <= load;
            if (load) out_data <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_response_arbiter.sv
// Scoreboard bench for response_arbiter: expected bytes queued with stimulus, popped on output handshakes.
// Tag expectations follow RESPONSE_ARBITER_TAG_EN.
module tb_response_arbiter;
   localparam int MB = 4;
   localparam int IC = 16;
`ifdef RESPONSE_ARBITER_TAG_EN
   localparam bit TAGS = 1'b1;
`else
   localparam bit TAGS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       asc_valid, asc_ready, stl_valid, stl_ready;
   logic       out_valid, out_ready;
   logic [7:0] asc_data, stl_data, out_data;
   logic [1:0] grant;

   int checks = 0;
   int failures = 0;
   logic [7:0] asc_src[$];
   logic [7:0] stl_src[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   response_arbiter #(.MAX_BURST(MB), .IDLE_CYCLES(IC)) dut (
      .clk(clk), .reset(reset),
      .asc_valid(asc_valid), .asc_ready(asc_ready), .asc_data(asc_data),
      .stl_valid(stl_valid), .stl_ready(stl_ready), .stl_data(stl_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .grant(grant)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_tag(input logic [7:0] t);
      if (TAGS) exp_q.push_back(t);
   endtask

   task automatic send_asc(input logic [7:0] b, input bit expect_it);
      asc_src.push_back(b);
      if (expect_it) exp_q.push_back(b);
   endtask

   task automatic send_stl(input logic [7:0] b, input bit expect_it);
      stl_src.push_back(b);
      if (expect_it) exp_q.push_back(b);
   endtask

   task automatic wait_drain(input string tag, input int lim);
      int n = 0;
      while ((exp_q.size() > 0 || asc_src.size() > 0 || stl_src.size() > 0) && n < lim) begin
         tick();
         n++;
      end
      chk({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic wait_grant(input string tag, input logic [1:0] g, input int lim);
      int n = 0;
      while (grant !== g && n < lim) begin
         tick();
         n++;
      end
      chk({tag, "_grant"}, grant, g);
   endtask

   task automatic wait_out_valid(input string tag, input int lim);
      int n = 0;
      while (out_valid !== 1'b1 && n < lim) begin
         tick();
         n++;
      end
      chk({tag, "_out_valid"}, out_valid, 1);
   endtask

   // source drivers and output monitor
   initial begin
      asc_valid = 1'b0;
      stl_valid = 1'b0;
      asc_data  = 8'h00;
      stl_data  = 8'h00;
      forever begin
         bit ah, sh;
         @(negedge clk);
         ah = asc_valid && asc_ready;
         sh = stl_valid && stl_ready;
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
            else chk("out_byte", out_data, exp_q.pop_front());
         end
         @(posedge clk);
         #1;
         if (ah && asc_src.size() > 0) void'(asc_src.pop_front());
         if (sh && stl_src.size() > 0) void'(stl_src.pop_front());
         asc_valid = asc_src.size() > 0;
         asc_data  = asc_valid ? asc_src[0] : 8'h00;
         stl_valid = stl_src.size() > 0;
         stl_data  = stl_valid ? stl_src[0] : 8'h00;
      end
   end

   initial begin
      logic [7:0] held;
      reset = 1'b1;
      out_ready = 1'b1;
      tick(2);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_grant", grant, 0);
      chk("rst_asc_ready", asc_ready, 0);
      chk("rst_stl_ready", stl_ready, 0);
      reset = 1'b0;
      tick();

      // ASC short burst, then idle timeout
      exp_tag(8'h61);
      send_asc(8'h11, 1'b1);
      send_asc(8'h22, 1'b1);
      tick(3);
      chk("asc_grant", grant, 2'b01);
      chk("nongrant_stl_ready", stl_ready, 0);
      wait_drain("asc2", 50);
      tick(5);
      chk("burst_held", grant, 2'b01);
      wait_grant("asc2_end", 2'b00, 30);
      chk("idle_asc_ready", asc_ready, 0);

      // single STL byte
      exp_tag(8'h73);
      send_stl(8'hA5, 1'b1);
      tick(3);
      chk("stl_grant", grant, 2'b10);
      wait_drain("stl1", 50);
      wait_grant("stl1_end", 2'b00, 40);

      // tie from reset: ASC burst fully before STL
      reset = 1'b1;
      exp_tag(8'h61);
      for (int i = 0; i < 3; i++) send_asc(8'hA0 + 8'(i), 1'b1);
      exp_tag(8'h73);
      for (int i = 0; i < 3; i++) send_stl(8'hB0 + 8'(i), 1'b1);
      tick(2);
      reset = 1'b0;
      tick(2);
      chk("tie_asc_first", grant, 2'b01);
      chk("tie_stl_ready", stl_ready, 0);
      wait_drain("tie", 120);
      wait_grant("tie_end", 2'b00, 40);

      // MAX_BURST fairness: STL 10 bytes with ASC waiting
      exp_tag(8'h73);
      for (int i = 0; i < 4; i++) send_stl(8'h30 + 8'(i), 1'b1);
      exp_tag(8'h61);
      exp_q.push_back(8'hC0);
      exp_q.push_back(8'hC1);
      exp_tag(8'h73);
      for (int i = 4; i < 8; i++) send_stl(8'h30 + 8'(i), 1'b1);
      exp_tag(8'h73);
      for (int i = 8; i < 10; i++) send_stl(8'h30 + 8'(i), 1'b1);
      wait_grant("fair_stl", 2'b10, 10);
      send_asc(8'hC0, 1'b0);
      send_asc(8'hC1, 1'b0);
      wait_grant("fair_asc", 2'b01, 20);
      wait_drain("fair", 200);
      wait_grant("fair_end", 2'b00, 40);

      // back-pressure stall
      out_ready = 1'b0;
      exp_tag(8'h61);
      send_asc(8'h51, 1'b1);
      send_asc(8'h52, 1'b1);
      send_asc(8'h53, 1'b1);
      wait_out_valid("stall", 10);
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, held);
         chk("stall_src_ready", asc_ready, 0);
      end
      out_ready = 1'b1;
      wait_drain("stall", 50);
      wait_grant("stall_end", 2'b00, 40);

      // reset mid-burst with a pending byte
      out_ready = 1'b0;
      send_asc(8'h71, 1'b0);
      send_asc(8'h72, 1'b0);
      wait_out_valid("midrst", 10);
      reset = 1'b1;
      exp_q.delete();
      asc_src.delete();
      stl_src.delete();
      tick();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_grant", grant, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      exp_tag(8'h61);
      send_asc(8'h81, 1'b1);
      exp_tag(8'h73);
      send_stl(8'h91, 1'b1);
      tick(2);
      chk("post_rst_tie", grant, 2'b01);
      wait_drain("post_rst", 100);
      wait_grant("post_rst_end", 2'b00, 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
